// File: rtl/frame_parity_pkg.sv
// frame_parity_pkg: shared receiver state encoding, framing constants and even-parity helpers.
package frame_parity_pkg;
  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;
  localparam int FRAME_LEN_DEFAULT = 16;
  localparam int WORD_W = 9;
  function automatic logic parity_bit(input logic [7:0] data);
    return ^data;
  endfunction
  function automatic logic parity_err(input logic [WORD_W-1:0] word);
    return ^word;
  endfunction
endpackage

// File: rtl/byte_parity_check.sv
// byte_parity_check: flags a 9-bit {parity, data} word whose total weight is odd.
module byte_parity_check
  import frame_parity_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic              err
);
  assign err = parity_err(word);
endmodule

// File: rtl/frame_receiver_with_parity.sv
// frame_receiver_with_parity: collects FRAME_LEN parity-checked bytes into a frame, valid/ack handoff, idle timeout.
// Optional saturating parity-error counter enabled by FRAME_RX_ERR_COUNT_EN.
module frame_receiver_with_parity
  import frame_parity_pkg::*;
#(
  parameter int FRAME_LEN      = FRAME_LEN_DEFAULT,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   rx_valid,
  input  logic [WORD_W-1:0]      rx_data_with_parity,
  output logic [FRAME_LEN*8-1:0] frame_data,
  output logic [FRAME_LEN-1:0]   parity_err_mask,
  output logic                   frame_valid,
  output logic                   frame_ok,
  input  logic                   frame_ack,
  output logic                   frame_abort,
  output logic                   busy,
  output logic [CNT_W-1:0]       err_count
);
  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  state_t           state;
  logic [IDX_W-1:0] byte_idx;
  logic [TMR_W-1:0] timer;
  logic             err;
  logic             last_word;
  logic             timed_out;
  byte_parity_check u_check (.word(rx_data_with_parity), .err(err));
  assign busy      = state != IDLE;
  assign frame_ok  = frame_valid && parity_err_mask == '0;
  assign last_word = byte_idx == IDX_W'(FRAME_LEN - 1);
  assign timed_out = timer == TMR_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      byte_idx        <= '0;
      timer           <= '0;
      frame_data      <= '0;
      parity_err_mask <= '0;
      frame_valid     <= 1'b0;
      frame_abort     <= 1'b0;
    end else begin
      frame_abort <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state           <= RECV;
          byte_idx        <= '0;
          timer           <= '0;
          parity_err_mask <= '0;
        end
        RECV: if (rx_valid) begin
          for (int i = 0; i < FRAME_LEN; i++)
            if (byte_idx == IDX_W'(i)) begin
              frame_data[8*i +: 8] <= rx_data_with_parity[7:0];
              parity_err_mask[i]   <= err;
            end
          byte_idx <= byte_idx + IDX_W'(1);
          timer    <= '0;
          if (last_word) begin
            state       <= DONE;
            frame_valid <= 1'b1;
          end
        end else if (timed_out) begin
          state           <= IDLE;
          frame_abort     <= 1'b1;
          parity_err_mask <= '0;
          timer           <= '0;
        end else begin
          timer <= timer + TMR_W'(1);
        end
        DONE: if (frame_ack) begin
          // ack together with start re-arms without passing through IDLE
          frame_valid <= 1'b0;
          state       <= start ? RECV : IDLE;
          if (start) begin
            byte_idx        <= '0;
            timer           <= '0;
            parity_err_mask <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef FRAME_RX_ERR_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) err_count <= '0;
    else if (state == RECV && rx_valid && err && err_count != '1) err_count <= err_count + CNT_W'(1);
  end
`else
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_frame_receiver_with_parity.sv
// tb_frame_receiver_with_parity: randomized frames checked against a slot/parity reference model.
module tb_frame_receiver_with_parity;
  localparam int FL = 16;
  localparam int TO = 64;
  logic clk = 1'b0;
  logic reset, start, rx_valid, frame_ack;
  logic [8:0] rx;
  logic [FL*8-1:0] frame_data, s_frame_data;
  logic [FL-1:0] mask, s_mask;
  logic frame_valid, frame_ok, frame_abort, busy;
  logic s_valid, s_ok, s_abort, s_busy;
  logic [15:0] err_count;
  logic [1:0] s_err_count;
  int checks = 0;
  int errors = 0;
  int errs = 0;
  logic [7:0] tx_bytes [FL];
  logic [FL-1:0] tx_bad;
  logic [FL*8-1:0] exp_data;
  logic [FL-1:0] exp_mask;
  always #5 clk = ~clk;
  frame_receiver_with_parity #(.FRAME_LEN(FL), .TIMEOUT_CYCLES(TO), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data_with_parity(rx),
    .frame_data(frame_data), .parity_err_mask(mask), .frame_valid(frame_valid), .frame_ok(frame_ok),
    .frame_ack(frame_ack), .frame_abort(frame_abort), .busy(busy), .err_count(err_count));
  frame_receiver_with_parity #(.FRAME_LEN(FL), .TIMEOUT_CYCLES(TO), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data_with_parity(rx),
    .frame_data(s_frame_data), .parity_err_mask(s_mask), .frame_valid(s_valid), .frame_ok(s_ok),
    .frame_ack(frame_ack), .frame_abort(s_abort), .busy(s_busy), .err_count(s_err_count));
  function automatic int lim(input int m);
`ifdef FRAME_RX_ERR_COUNT_EN
    return errs > m ? m : errs;
`else
    return 0;
`endif
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Word i lands in slot i; its mask bit is the odd-weight flag; start and junk are noise.
  task automatic send_frame(input bit with_start);
    frame_ack = 1'b0;
    if (with_start) begin
      start = 1'b1; rx_valid = 1'b1; rx = {1'b1, 8'hAA};
      tick();
    end
    for (int i = 0; i < FL; i++) begin
      repeat ($urandom_range(0, 3)) begin
        rx_valid = 1'b0; start = 1'($urandom_range(0, 1)); rx = 9'($urandom);
        tick();
      end
      rx = {(^tx_bytes[i]) ^ tx_bad[i], tx_bytes[i]};
      rx_valid = 1'b1; start = 1'($urandom_range(0, 1));
      exp_data[8*i +: 8] = tx_bytes[i];
      exp_mask[i] = tx_bad[i];
      if (tx_bad[i]) errs++;
      tick();
      if (i < FL - 1) begin
        checks++;
        if (frame_valid !== 1'b0) begin errors++; $display("FAIL early_valid byte %0d got %b exp 0", i, frame_valid); end
      end
    end
    rx_valid = 1'b0; start = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx = '0; frame_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    checks += 4;
    if ({frame_valid, frame_ok, frame_abort, busy} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {frame_valid, frame_ok, frame_abort, busy}); end
    if (frame_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", frame_data); end
    if (mask !== '0) begin errors++; $display("FAIL reset_mask got %h exp 0", mask); end
    if (err_count !== 16'd0 || s_err_count !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", err_count, s_err_count); end
  endtask
  task automatic test_frames(input string name, input int kind);
    for (int i = 0; i < FL; i++) tx_bytes[i] = kind == 2 ? 8'($urandom) : 8'(i);
    tx_bad = kind == 0 ? '0 : kind == 1 ? 16'h0020 : 16'($urandom);
    send_frame(1'b1);
    checks += 6;
    if (frame_valid !== 1'b1) begin errors++; $display("FAIL %s_valid got %b exp 1", name, frame_valid); end
    if (frame_data !== exp_data) begin errors++; $display("FAIL %s_data got %h exp %h", name, frame_data, exp_data); end
    if (mask !== exp_mask) begin errors++; $display("FAIL %s_mask got %h exp %h", name, mask, exp_mask); end
    if (frame_ok !== (exp_mask == '0)) begin errors++; $display("FAIL %s_ok got %b exp %b", name, frame_ok, exp_mask == '0); end
    if (err_count !== 16'(lim(65535))) begin errors++; $display("FAIL %s_cnt got %0d exp %0d", name, err_count, lim(65535)); end
    if (s_err_count !== 2'(lim(3))) begin errors++; $display("FAIL %s_satcnt got %0d exp %0d", name, s_err_count, lim(3)); end
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    checks++;
    if (frame_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s_ack got v%b b%b exp v0 b0", name, frame_valid, busy); end
  endtask
  task automatic test_timeout();
    frame_ack = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (TO - 1) tick();
    checks++;
    if (busy !== 1'b1 || frame_abort !== 1'b0) begin errors++; $display("FAIL to_pre_first got b%b a%b exp b1 a0", busy, frame_abort); end
    tick();
    checks++;
    if (frame_abort !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL to_first got a%b b%b exp a1 b0", frame_abort, busy); end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int w = 0; w < 4; w++) begin
      if (w == 3) repeat (TO - 1) begin
        rx_valid = 1'b0;
        tick();
        checks++;
        if (frame_abort !== 1'b0) begin errors++; $display("FAIL to_gap63 got %b exp 0", frame_abort); end
      end
      rx = {1'b0, 8'h03}; rx_valid = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
    repeat (TO - 1) tick();
    checks++;
    if (frame_abort !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_63 got a%b b%b exp a0 b1", frame_abort, busy); end
    tick();
    checks += 2;
    if (frame_abort !== 1'b1 || busy !== 1'b0 || frame_valid !== 1'b0) begin errors++; $display("FAIL to_64 got a%b b%b v%b exp a1 b0 v0", frame_abort, busy, frame_valid); end
    if (mask !== '0) begin errors++; $display("FAIL to_mask got %h exp 0", mask); end
    tick();
    frame_ack = 1'b0;
    checks++;
    if (frame_abort !== 1'b0 || frame_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL to_after got a%b v%b b%b exp 000", frame_abort, frame_valid, busy); end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < FL; i++) tx_bytes[i] = 8'($urandom);
    tx_bad = 16'($urandom);
    send_frame(1'b1);
    for (int c = 0; c < 10; c++) begin
      rx_valid = 1'(c % 2); rx = 9'($urandom); start = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (frame_valid !== 1'b1 || frame_data !== exp_data || mask !== exp_mask)
        begin errors++; $display("FAIL hold_%0d got v%b %h/%h exp v1 %h/%h", c, frame_valid, frame_data, mask, exp_data, exp_mask); end
    end
    rx_valid = 1'b0; frame_ack = 1'b1; start = 1'b1;
    tick();
    frame_ack = 1'b0; start = 1'b0;
    checks++;
    if (frame_valid !== 1'b0 || busy !== 1'b1 || mask !== '0) begin errors++; $display("FAIL rearm got v%b b%b m%h exp v0 b1 m0", frame_valid, busy, mask); end
    for (int i = 0; i < FL; i++) tx_bytes[i] = 8'(8'hF0 + i);
    tx_bad = '0;
    send_frame(1'b0);
    checks += 3;
    if (frame_valid !== 1'b1 || frame_ok !== 1'b1) begin errors++; $display("FAIL b2b_ok got v%b o%b exp 11", frame_valid, frame_ok); end
    if (frame_data !== exp_data) begin errors++; $display("FAIL b2b_data got %h exp %h", frame_data, exp_data); end
    if (err_count !== 16'(lim(65535))) begin errors++; $display("FAIL b2b_cnt got %0d exp %0d", err_count, lim(65535)); end
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask
  task automatic test_reset_mid();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rx = {1'b1, 8'(i)}; rx_valid = 1'b1;
      tick();
    end
    rx_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; errs = 0;
    checks += 3;
    if ({frame_valid, frame_ok, frame_abort, busy} !== 4'b0) begin errors++; $display("FAIL rmid_flags got %b exp 0000", {frame_valid, frame_ok, frame_abort, busy}); end
    if (frame_data !== '0 || mask !== '0) begin errors++; $display("FAIL rmid_buf got %h/%h exp 0/0", frame_data, mask); end
    if (err_count !== 16'd0 || s_err_count !== 2'd0) begin errors++; $display("FAIL rmid_cnt got %0d/%0d exp 0/0", err_count, s_err_count); end
    test_frames("post_reset", 0);
  endtask
  task automatic test_saturation();
    for (int i = 0; i < FL; i++) tx_bytes[i] = 8'($urandom);
    tx_bad = 16'h001F;
    send_frame(1'b1);
    checks++;
    if (s_err_count !== 2'(lim(3)) || err_count !== 16'(lim(65535))) begin errors++; $display("FAIL sat5 got %0d/%0d exp %0d/%0d", s_err_count, err_count, lim(3), lim(65535)); end
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    test_frames("sat_hold", 1);
  endtask
  initial begin
    test_reset();
    test_frames("clean", 0);
    test_frames("parity", 1);
    repeat (3) test_frames("random", 2);
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
